// File: rtl/mor1kx_sprs_pkg.sv
// Shared SPR-bus definitions: group count and bases, bus FSM states,
// requester identities, and the address-to-group decode.
package mor1kx_sprs_pkg;

  localparam int SPR_NUM_GROUPS = 12;

  localparam logic [15:0] SPR_SYS_BASE  = {5'd0,  11'd0};
  localparam logic [15:0] SPR_DMMU_BASE = {5'd1,  11'd0};
  localparam logic [15:0] SPR_IMMU_BASE = {5'd2,  11'd0};
  localparam logic [15:0] SPR_DC_BASE   = {5'd3,  11'd0};
  localparam logic [15:0] SPR_IC_BASE   = {5'd4,  11'd0};
  localparam logic [15:0] SPR_MAC_BASE  = {5'd5,  11'd0};
  localparam logic [15:0] SPR_DU_BASE   = {5'd6,  11'd0};
  localparam logic [15:0] SPR_PC_BASE   = {5'd7,  11'd0};
  localparam logic [15:0] SPR_PM_BASE   = {5'd8,  11'd0};
  localparam logic [15:0] SPR_PIC_BASE  = {5'd9,  11'd0};
  localparam logic [15:0] SPR_TT_BASE   = {5'd10, 11'd0};
  localparam logic [15:0] SPR_FPU_BASE  = {5'd11, 11'd0};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } spr_bus_state_t;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DU  = 1'b1
  } spr_requester_t;

  function automatic logic [4:0] spr_group(input logic [15:0] addr);
    return addr[15:11];
  endfunction

endpackage

// File: rtl/mor1kx_spr_rr_arb.sv
// Two-way round-robin arbiter between CPU and debug unit; the last winner
// loses the next tie. History only advances when a grant is actually taken.
module mor1kx_spr_rr_arb
  import mor1kx_sprs_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           cpu_req_i,
  input  logic           du_req_i,
  input  logic           take_i,
  output spr_requester_t grant_o,
  output logic           valid_o
);

  spr_requester_t last_q, last_d;

  always_comb begin
    valid_o = cpu_req_i | du_req_i;
    if (cpu_req_i && du_req_i) begin
      grant_o = (last_q == REQ_DU) ? REQ_CPU : REQ_DU;
    end else if (du_req_i) begin
      grant_o = REQ_DU;
    end else begin
      grant_o = REQ_CPU;
    end
    if (take_i && valid_o) begin
      last_d = grant_o;
    end else begin
      last_d = last_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= REQ_DU;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mor1kx_spr_bus_ctrl.sv
// SPR bus sequencer: arbitrates CPU/DU accesses, strobes the owning group,
// waits for its acknowledge under a timeout and returns data or error.
module mor1kx_spr_bus_ctrl
  import mor1kx_sprs_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 15,
  parameter logic [11:0] GROUP_PRESENT  = 12'hFFF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cpu_req_i,
  input  logic         cpu_we_i,
  input  logic [15:0]  cpu_addr_i,
  input  logic [31:0]  cpu_wdata_i,
  output logic         cpu_ack_o,
  output logic         cpu_err_o,
  output logic [31:0]  cpu_rdata_o,
  input  logic         du_req_i,
  input  logic         du_we_i,
  input  logic [15:0]  du_addr_i,
  input  logic [31:0]  du_wdata_i,
  output logic         du_ack_o,
  output logic         du_err_o,
  output logic [31:0]  du_rdata_o,
  output logic [11:0]  spr_access_o,
  output logic         spr_we_o,
  output logic [15:0]  spr_addr_o,
  output logic [31:0]  spr_wdata_o,
  input  logic [11:0]  spr_ack_i,
  input  logic [383:0] spr_rdata_i
);

  localparam logic [31:0] PRESENT_MASK = {20'd0, GROUP_PRESENT};
  localparam logic [7:0]  TIMEOUT_W    = 8'(TIMEOUT_CYCLES);

  spr_bus_state_t state_q, state_d;
  spr_requester_t owner_q, arb_grant_s, resp_owner_s;
  logic        arb_valid_s, we_q, grant_we_s, grant_present_s;
  logic [15:0] addr_q, grant_addr_s;
  logic [31:0] wdata_q, grant_wdata_s, unit_rdata_s, resp_rdata_s;
  logic [4:0]  grant_group_s;
  logic [3:0]  grp_q, strobe_idx_s;
  logic [7:0]  cnt_q, cnt_d, cnt_inc_s;
  logic        ack_hit_s, timeout_s, owner_req_s, resp_err_s, deliver_s;
  logic        cpu_ack_q, cpu_ack_d, cpu_err_q, cpu_err_d, du_ack_q, du_ack_d, du_err_q, du_err_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d, du_rdata_q, du_rdata_d;
  logic [11:0] access_q, access_d;
  logic        spr_we_q, spr_we_d;

  mor1kx_spr_rr_arb u_arb (
    .clk      (clk),
    .rst      (rst),
    .cpu_req_i(cpu_req_i),
    .du_req_i (du_req_i),
    .take_i   (state_q == IDLE),
    .grant_o  (arb_grant_s),
    .valid_o  (arb_valid_s)
  );

  assign grant_addr_s    = (arb_grant_s == REQ_CPU) ? cpu_addr_i  : du_addr_i;
  assign grant_wdata_s   = (arb_grant_s == REQ_CPU) ? cpu_wdata_i : du_wdata_i;
  assign grant_we_s      = (arb_grant_s == REQ_CPU) ? cpu_we_i    : du_we_i;
  assign grant_group_s   = spr_group(grant_addr_s);
  assign grant_present_s = PRESENT_MASK[grant_group_s];
  assign owner_req_s     = (owner_q == REQ_CPU) ? cpu_req_i : du_req_i;
  assign ack_hit_s       = spr_ack_i[grp_q];
  assign unit_rdata_s    = spr_rdata_i[{grp_q, 5'd0} +: 32];
  // Saturating so a huge TIMEOUT_CYCLES can never wrap back into the wait window.
  assign cnt_inc_s       = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  assign timeout_s       = (cnt_inc_s >= TIMEOUT_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (arb_valid_s) begin
          state_d = grant_present_s ? ACCESS : RESP;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (ack_hit_s || timeout_s) begin
          state_d = RESP;
        end else begin
          state_d = ACCESS;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = (state_q == ACCESS) ? cnt_inc_s : 8'd0;
    if (state_q == ACCESS) begin
      if (ack_hit_s) begin
        resp_rdata_s = we_q ? 32'd0 : unit_rdata_s;
        resp_err_s   = 1'b0;
      end else begin
        resp_rdata_s = 32'd0;
        resp_err_s   = timeout_s;
      end
    end else begin
      resp_rdata_s = 32'd0;
      resp_err_s   = 1'b0;
    end
    // An owner that dropped req mid-transaction gets no acknowledge.
    deliver_s    = (state_d == RESP) && ((state_q == IDLE) || owner_req_s);
    resp_owner_s = (state_q == IDLE) ? arb_grant_s : owner_q;
    cpu_ack_d    = deliver_s && (resp_owner_s == REQ_CPU);
    du_ack_d     = deliver_s && (resp_owner_s == REQ_DU);
    cpu_rdata_d  = cpu_ack_d ? resp_rdata_s : 32'd0;
    cpu_err_d    = cpu_ack_d && resp_err_s;
    du_rdata_d   = du_ack_d ? resp_rdata_s : 32'd0;
    du_err_d     = du_ack_d && resp_err_s;
    strobe_idx_s = (state_q == IDLE) ? grant_group_s[3:0] : grp_q;
    if (state_d == ACCESS) begin
      access_d = 12'd1 << strobe_idx_s;
      spr_we_d = (state_q == IDLE) ? grant_we_s : we_q;
    end else begin
      access_d = 12'd0;
      spr_we_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q     <= REQ_CPU;
      we_q        <= 1'b0;
      addr_q      <= 16'd0;
      wdata_q     <= 32'd0;
      grp_q       <= 4'd0;
      cnt_q       <= 8'd0;
      cpu_ack_q   <= 1'b0;
      cpu_err_q   <= 1'b0;
      cpu_rdata_q <= 32'd0;
      du_ack_q    <= 1'b0;
      du_err_q    <= 1'b0;
      du_rdata_q  <= 32'd0;
      access_q    <= 12'd0;
      spr_we_q    <= 1'b0;
    end else begin
      if ((state_q == IDLE) && arb_valid_s) begin
        owner_q <= arb_grant_s;
        we_q    <= grant_we_s;
        addr_q  <= grant_addr_s;
        wdata_q <= grant_wdata_s;
        grp_q   <= grant_group_s[3:0];
      end
      cnt_q       <= cnt_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_err_q   <= cpu_err_d;
      cpu_rdata_q <= cpu_rdata_d;
      du_ack_q    <= du_ack_d;
      du_err_q    <= du_err_d;
      du_rdata_q  <= du_rdata_d;
      access_q    <= access_d;
      spr_we_q    <= spr_we_d;
    end
  end

  assign cpu_ack_o    = cpu_ack_q;
  assign cpu_err_o    = cpu_err_q;
  assign cpu_rdata_o  = cpu_rdata_q;
  assign du_ack_o     = du_ack_q;
  assign du_err_o     = du_err_q;
  assign du_rdata_o   = du_rdata_q;
  assign spr_access_o = access_q;
  assign spr_we_o     = spr_we_q;
  assign spr_addr_o   = addr_q;
  assign spr_wdata_o  = wdata_q;

endmodule

// File: tb/tb_mor1kx_spr_bus_ctrl.sv
// Directed bench for mor1kx_spr_bus_ctrl; a second instance with groups 8..11
// absent covers the absent-group path. Inputs driven and outputs sampled at negedge.
module tb_mor1kx_spr_bus_ctrl;

  logic clk = 1'b0;
  logic rst, cpu_req, cpu_we, du_req, du_we, req2;
  logic [15:0] cpu_addr, du_addr;
  logic [31:0] cpu_wdata, du_wdata;
  logic [11:0] spr_ack;
  logic [383:0] spr_rdata;
  logic cpu_ack, cpu_err, du_ack, du_err, spr_we;
  logic [31:0] cpu_rdata, du_rdata, spr_wdata;
  logic [11:0] spr_access;
  logic [15:0] spr_addr;
  logic b_cpu_ack, b_cpu_err, b_du_ack, b_du_err, b_we;
  logic [31:0] b_cpu_rdata, b_du_rdata, b_wdata;
  logic [11:0] b_access;
  logic [15:0] b_addr;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mor1kx_spr_bus_ctrl #(.TIMEOUT_CYCLES(15), .GROUP_PRESENT(12'hFFF)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_ack_o(cpu_ack), .cpu_err_o(cpu_err), .cpu_rdata_o(cpu_rdata),
    .du_req_i(du_req), .du_we_i(du_we), .du_addr_i(du_addr), .du_wdata_i(du_wdata),
    .du_ack_o(du_ack), .du_err_o(du_err), .du_rdata_o(du_rdata),
    .spr_access_o(spr_access), .spr_we_o(spr_we), .spr_addr_o(spr_addr), .spr_wdata_o(spr_wdata),
    .spr_ack_i(spr_ack), .spr_rdata_i(spr_rdata)
  );

  mor1kx_spr_bus_ctrl #(.TIMEOUT_CYCLES(15), .GROUP_PRESENT(12'h0FF)) dut_abs (
    .clk(clk), .rst(rst),
    .cpu_req_i(req2), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_ack_o(b_cpu_ack), .cpu_err_o(b_cpu_err), .cpu_rdata_o(b_cpu_rdata),
    .du_req_i(1'b0), .du_we_i(du_we), .du_addr_i(du_addr), .du_wdata_i(du_wdata),
    .du_ack_o(b_du_ack), .du_err_o(b_du_err), .du_rdata_o(b_du_rdata),
    .spr_access_o(b_access), .spr_we_o(b_we), .spr_addr_o(b_addr), .spr_wdata_o(b_wdata),
    .spr_ack_i(spr_ack), .spr_rdata_i(spr_rdata)
  );

  task automatic test_reset();
    rst = 1'b1; cpu_req = 1'b0; du_req = 1'b0; req2 = 1'b0; cpu_we = 1'b0; du_we = 1'b0;
    cpu_addr = 16'h0; du_addr = 16'h0; cpu_wdata = 32'h0; du_wdata = 32'h0;
    spr_ack = 12'h0; spr_rdata = '0;
    repeat (3) @(negedge clk);
    checks++; if ({cpu_ack, cpu_err, du_ack, du_err} !== 4'b0) begin errors++; $display("FAIL reset_acks got %b exp 0000", {cpu_ack, cpu_err, du_ack, du_err}); end
    checks++; if ({spr_access, spr_we} !== 13'h0) begin errors++; $display("FAIL reset_strobe got %h exp 0", {spr_access, spr_we}); end
    checks++; if ({spr_addr, spr_wdata} !== 48'h0) begin errors++; $display("FAIL reset_addr_wdata got %h exp 0", {spr_addr, spr_wdata}); end
    checks++; if ({cpu_rdata, du_rdata} !== 64'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", {cpu_rdata, du_rdata}); end
    rst = 1'b0;
  endtask

  task automatic test_cpu_read();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0011;
    @(negedge clk);
    checks++; if (spr_access !== 12'h001) begin errors++; $display("FAIL rd_strobe got %h exp 001", spr_access); end
    checks++; if ({spr_addr, spr_we, cpu_ack} !== {16'h0011, 2'b00}) begin errors++; $display("FAIL rd_addr_we_ack got %h exp 00044", {spr_addr, spr_we, cpu_ack}); end
    spr_ack = 12'h001; spr_rdata[31:0] = 32'h0000_8001;
    @(negedge clk);
    checks++; if ({cpu_ack, cpu_err} !== 2'b10) begin errors++; $display("FAIL rd_ack got %b exp 10", {cpu_ack, cpu_err}); end
    checks++; if (cpu_rdata !== 32'h0000_8001) begin errors++; $display("FAIL rd_data got %h exp 00008001", cpu_rdata); end
    checks++; if (spr_access !== 12'h000) begin errors++; $display("FAIL rd_strobe_off got %h exp 000", spr_access); end
    spr_ack = 12'h0; cpu_req = 1'b0;
    @(negedge clk);
    checks++; if ({cpu_ack, cpu_rdata} !== 33'h0) begin errors++; $display("FAIL rd_after got %h exp 0", {cpu_ack, cpu_rdata}); end
  endtask

  task automatic test_du_write();
    du_req = 1'b1; du_we = 1'b1; du_addr = 16'h4802; du_wdata = 32'hA5A5_A5A5;
    spr_rdata[9*32 +: 32] = 32'hDEAD_BEEF;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      checks++;
      if ({spr_access, spr_we, spr_wdata, du_ack} !== {12'h200, 1'b1, 32'hA5A5_A5A5, 1'b0}) begin
        errors++; $display("FAIL wr_strobe cycle %0d got acc=%h we=%b wd=%h ack=%b exp acc=200 we=1 wd=a5a5a5a5 ack=0", k, spr_access, spr_we, spr_wdata, du_ack);
      end
      spr_ack = (k == 2) ? 12'h001 : ((k == 4) ? 12'h200 : 12'h000);
    end
    @(negedge clk);
    checks++; if ({du_ack, du_err, cpu_ack} !== 3'b100) begin errors++; $display("FAIL wr_ack got %b exp 100", {du_ack, du_err, cpu_ack}); end
    checks++; if (du_rdata !== 32'h0) begin errors++; $display("FAIL wr_rdata got %h exp 0", du_rdata); end
    spr_ack = 12'h0; du_req = 1'b0; du_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0011;
    du_req = 1'b1; du_we = 1'b0; du_addr = 16'h3000;
    spr_rdata[31:0] = 32'h0000_0011; spr_rdata[6*32 +: 32] = 32'h0000_0066;
    @(negedge clk);
    checks++; if (spr_access !== 12'h001) begin errors++; $display("FAIL tie1_grant got %h exp 001", spr_access); end
    spr_ack = 12'h001;
    @(negedge clk);
    checks++; if ({cpu_ack, du_ack, cpu_rdata} !== {2'b10, 32'h11}) begin errors++; $display("FAIL tie1_ack got %h exp 200000011", {cpu_ack, du_ack, cpu_rdata}); end
    spr_ack = 12'h0; cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (spr_access !== 12'h040) begin errors++; $display("FAIL tie1_du got %h exp 040", spr_access); end
    spr_ack = 12'h040;
    @(negedge clk);
    checks++; if ({du_ack, cpu_ack, du_rdata} !== {2'b10, 32'h66}) begin errors++; $display("FAIL tie1_du_ack got %h exp 200000066", {du_ack, cpu_ack, du_rdata}); end
    spr_ack = 12'h0; cpu_req = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (spr_access !== 12'h001) begin errors++; $display("FAIL tie2_grant got %h exp 001", spr_access); end
    spr_ack = 12'h001;
    @(negedge clk);
    checks++; if ({cpu_ack, du_ack} !== 2'b10) begin errors++; $display("FAIL tie2_ack got %b exp 10", {cpu_ack, du_ack}); end
    spr_ack = 12'h0; cpu_req = 1'b0; du_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_absent();
    req2 = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h5000;
    spr_ack = 12'h400; spr_rdata[10*32 +: 32] = 32'h1010_1010;
    @(negedge clk);
    checks++; if ({b_cpu_ack, b_cpu_err, b_cpu_rdata} !== {2'b10, 32'h0}) begin errors++; $display("FAIL absent_tt got %h exp 200000000", {b_cpu_ack, b_cpu_err, b_cpu_rdata}); end
    checks++; if (b_access !== 12'h000) begin errors++; $display("FAIL absent_tt_strobe got %h exp 000", b_access); end
    req2 = 1'b0; spr_ack = 12'h0;
    @(negedge clk);
    checks++; if (b_cpu_ack !== 1'b0) begin errors++; $display("FAIL absent_tt_once got %b exp 0", b_cpu_ack); end
    cpu_req = 1'b1; cpu_addr = 16'hF800;
    @(negedge clk);
    checks++; if ({cpu_ack, cpu_err, cpu_rdata, spr_access} !== {2'b10, 32'h0, 12'h0}) begin errors++; $display("FAIL absent_g31 got %h exp 200000000000", {cpu_ack, cpu_err, cpu_rdata, spr_access}); end
    cpu_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1800;
    spr_ack = 12'hFF7; spr_rdata[3*32 +: 32] = 32'h3333_3333;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      checks++;
      if ({spr_access, cpu_ack} !== {12'h008, 1'b0}) begin errors++; $display("FAIL to_strobe cycle %0d got acc=%h ack=%b exp acc=008 ack=0", k, spr_access, cpu_ack); end
    end
    @(negedge clk);
    checks++; if ({cpu_ack, cpu_err, cpu_rdata} !== {2'b11, 32'h0}) begin errors++; $display("FAIL to_ack got %h exp 300000000", {cpu_ack, cpu_err, cpu_rdata}); end
    checks++; if (spr_access !== 12'h000) begin errors++; $display("FAIL to_strobe_off got %h exp 000", spr_access); end
    cpu_req = 1'b0; spr_ack = 12'h0;
    @(negedge clk);
    checks++; if ({cpu_ack, cpu_err} !== 2'b00) begin errors++; $display("FAIL to_err_clear got %b exp 00", {cpu_ack, cpu_err}); end
    cpu_req = 1'b1; cpu_addr = 16'h0011; spr_rdata[31:0] = 32'h0000_8001;
    @(negedge clk);
    spr_ack = 12'h001;
    @(negedge clk);
    checks++; if ({cpu_ack, cpu_err, cpu_rdata} !== {2'b10, 32'h8001}) begin errors++; $display("FAIL to_next got %h exp 200008001", {cpu_ack, cpu_err, cpu_rdata}); end
    cpu_req = 1'b0; spr_ack = 12'h0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    du_req = 1'b1; du_we = 1'b1; du_addr = 16'h4802; du_wdata = 32'h1234_5678;
    @(negedge clk);
    checks++; if ({spr_access, spr_we} !== {12'h200, 1'b1}) begin errors++; $display("FAIL rm_strobe got %h exp 401", {spr_access, spr_we}); end
    rst = 1'b1; spr_ack = 12'h200;
    @(negedge clk);
    checks++; if ({spr_access, spr_we, spr_addr, spr_wdata} !== 61'h0) begin errors++; $display("FAIL rm_bus got acc=%h we=%b a=%h wd=%h exp 0", spr_access, spr_we, spr_addr, spr_wdata); end
    checks++; if ({du_ack, du_err, du_rdata} !== 34'h0) begin errors++; $display("FAIL rm_ack got %h exp 0", {du_ack, du_err, du_rdata}); end
    rst = 1'b0; du_req = 1'b0; spr_ack = 12'h0;
    repeat (2) @(negedge clk);
    checks++; if ({du_ack, cpu_ack, spr_access} !== 14'h0) begin errors++; $display("FAIL rm_after got %h exp 0", {du_ack, cpu_ack, spr_access}); end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_du_write();
    test_back_to_back();
    test_absent();
    test_timeout();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
